// File: rtl/seq_pattern_tx.sv
// Serializes valid/ready-accepted words MSB-first onto out_bit, optionally behind a sync header,
// and guarantees an idle gap between frames so a downstream pattern detector sees clean framing.
module seq_pattern_tx #(
  parameter int                 DATA_W      = 8,
  parameter int                 HDR_LEN     = 4,
  parameter logic [HDR_LEN-1:0] HDR_PATTERN = 4'b1011,
  parameter int                 GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hdr_en,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  localparam int               CNT_W     = 6;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic             ONE_BIT   = (DATA_W == 1);

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [HDR_LEN-1:0]  hdr_sr;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          count_inc;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign count_inc = (frame_count == 8'hFF) ? frame_count : frame_count + 8'd1;

  // out_bit is registered one step ahead: the state names the bit currently on the wire,
  // and cnt holds how many bits of that section remain after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      hdr_sr      <= '0;
      cnt         <= '0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          if (in_valid) begin
            out_valid <= 1'b1;
            if (hdr_en) begin
              state   <= HDR;
              out_bit <= HDR_PATTERN[HDR_LEN-1];
              hdr_sr  <= HDR_PATTERN << 1;
              shreg   <= in_data;
              cnt     <= HDR_LAST;
            end else begin
              state   <= DATA;
              out_bit <= in_data[DATA_W-1];
              shreg   <= in_data << 1;
              cnt     <= DATA_LAST;
              if (ONE_BIT) begin
                frame_done  <= 1'b1;
                frame_count <= count_inc;
              end
            end
          end
        end
        HDR: begin
          out_valid <= 1'b1;
          if (cnt != '0) begin
            out_bit <= hdr_sr[HDR_LEN-1];
            hdr_sr  <= hdr_sr << 1;
            cnt     <= cnt - 1'b1;
          end else begin
            state   <= DATA;
            out_bit <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            cnt     <= DATA_LAST;
            if (ONE_BIT) begin
              frame_done  <= 1'b1;
              frame_count <= count_inc;
            end
          end
        end
        DATA: begin
          if (cnt != '0) begin
            out_valid <= 1'b1;
            out_bit   <= shreg[DATA_W-1];
            shreg     <= shreg << 1;
            cnt       <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              frame_done  <= 1'b1;
              frame_count <= count_inc;
            end
          end else begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            cnt       <= GAP_LOAD;
            state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: framing, gaps, reset recovery, saturation and 1011 loopback.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       hdr_en;
  logic       out_bit;
  logic       out_valid;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.DATA_W(8), .HDR_LEN(4), .HDR_PATTERN(4'b1011), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .hdr_en(hdr_en), .out_bit(out_bit), .out_valid(out_valid), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  // Reference 1011 detector fed from the serial line, held at 0 when out_valid is low
  logic [2:0] hist;
  logic       seq_seen;
  logic       din;
  assign din = out_valid & out_bit;
  always_ff @(posedge clk) begin
    if (reset) begin
      hist     <= 3'b000;
      seq_seen <= 1'b0;
    end else begin
      hist     <= {hist[1:0], din};
      seq_seen <= ({hist, din} == 4'b1011);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Accepts one word, checks every frame bit, the gap cycle, and the return to IDLE.
  task automatic send_frame(input logic h, input logic [7:0] d);
    logic [11:0] e;
    int n;
    e = h ? {4'b1011, d} : {4'b0000, d};
    n = h ? 12 : 8;
    chk1("ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1; hdr_en = h; in_data = d;
    tick();
    in_valid = 1'b0; hdr_en = ~h; in_data = ~d;
    for (int i = 0; i < n; i++) begin
      chk1("frame_valid", out_valid, 1'b1);
      chk1("frame_bit", out_bit, e[n-1-i]);
      chk1("frame_done", frame_done, (i == n - 1));
      chk1("ready_in_frame", in_ready, 1'b0);
      tick();
    end
    chk1("gap_valid", out_valid, 1'b0);
    chk1("gap_bit", out_bit, 1'b0);
    chk1("gap_ready", in_ready, 1'b0);
    tick();
    chk1("idle_ready", in_ready, 1'b1);
    chk1("idle_valid", out_valid, 1'b0);
  endtask

  initial begin
    int waited;
    reset = 1'b1; in_valid = 1'b0; hdr_en = 1'b0; in_data = 8'h00;
    tick(); tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_bit", out_bit, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_count", frame_count, 8'd0);
    reset = 1'b0;
    tick();
    chk1("post_rst_ready", in_ready, 1'b1);

    // Header frame A5: 1011 10100101
    send_frame(1'b1, 8'hA5);
    chk8("count_after_a5", frame_count, 8'd1);

    // No-header frame 0F
    send_frame(1'b0, 8'h0F);
    chk8("count_after_0f", frame_count, 8'd2);

    // Back-to-back with in_valid held high: FF then 00
    in_valid = 1'b1; hdr_en = 1'b0; in_data = 8'hFF;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk1("b2b_ff_valid", out_valid, 1'b1);
      chk1("b2b_ff_bit", out_bit, 1'b1);
      chk1("b2b_ff_ready", in_ready, 1'b0);
      tick();
    end
    chk1("b2b_gap1_valid", out_valid, 1'b0);
    chk1("b2b_gap1_ready", in_ready, 1'b0);
    tick();
    chk1("b2b_gap2_valid", out_valid, 1'b0);
    chk1("b2b_gap2_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("b2b_00_valid", out_valid, 1'b1);
      chk1("b2b_00_bit", out_bit, 1'b0);
      chk1("b2b_00_done", frame_done, (i == 7));
      tick();
    end
    tick();
    chk8("count_after_b2b", frame_count, 8'd4);

    // Reset during header bit 3
    in_valid = 1'b1; hdr_en = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk1("hdr_bit3", out_bit, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("midrst_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk8("midrst_count", frame_count, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk1("midrst_no_done", frame_done, 1'b0);
      chk1("midrst_quiet", out_valid, 1'b0);
      tick();
    end
    send_frame(1'b1, 8'h3C);
    chk8("count_after_recover", frame_count, 8'd1);

    // Saturation: continuous no-header frames, 10 cycles each
    in_valid = 1'b1; hdr_en = 1'b0; in_data = 8'h55;
    repeat (100) tick();
    chk8("count_mid", frame_count, 8'd11);
    repeat (2600) tick();
    chk8("count_sat", frame_count, 8'd255);
    repeat (30) tick();
    chk8("count_hold", frame_count, 8'd255);
    in_valid = 1'b0;
    waited = 0;
    while (busy && waited < 20) begin
      tick();
      waited++;
    end
    chk1("drain_idle", busy, 1'b0);

    // Loopback into 1011 detector: header then all-zero payload
    in_valid = 1'b1; hdr_en = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    for (int m = 1; m <= 20; m++) begin
      chk1("loop_seq_seen", seq_seen, (m == 5));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", pass_cnt, total);
    $fatal(1, "timeout");
  end

endmodule
